lsu: RTL

Parametrised load/store unit, the next generation of the core's single-cycle combinational memory read path. It replaces the zero-latency data read with a valid/ready request port from the execute stage and a variable-latency memory port. It supports byte, half, word and, when XLEN=64, double accesses, with lane alignment, write-mask generation, sign/zero extension and misalignment detection. It sits between the decode/ALU logic (address = src1 + imm) and the DPI-backed data memory.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_lane.sv | 43 ++++
 rtl/lsu.sv | 128 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the access-size decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } lsu_state_e;

    typedef struct packed {
        logic [3:0] nbytes;
        logic       uns;
    } size_info_t;

    // Encoding 111 decodes as 8 bytes; the caller flags it as an error.
    function automatic size_info_t size_decode(input logic [2:0] f3);
        size_info_t s;
        s.uns = f3[2];
        case (f3[1:0])
            2'b00:   s.nbytes = 4'd1;
            2'b01:   s.nbytes = 4'd2;
            2'b10:   s.nbytes = 4'd4;
            default: s.nbytes = 4'd8;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store data/mask shift into the lane, load data shift
// down and sign/zero extension.
module lsu_lane #(
    parameter int unsigned XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [3:0]                nbytes,
    input  logic                      uns,
    input  logic [XLEN-1:0]           wdata,
    input  logic [XLEN-1:0]           rdata,
    output logic [XLEN-1:0]           wdata_sh,
    output logic [XLEN/8-1:0]         wmask,
    output logic [XLEN-1:0]           rdata_ext
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned IDX_W = $clog2(XLEN);

    logic [8:0]        ones;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   keep;
    logic [31:0]       nbits;
    logic [IDX_W-1:0]  sidx;
    logic              sgn;

    always_comb begin
        ones     = (9'd1 << nbytes) - 9'd1;
        wmask    = NB'(ones) << off;
        wdata_sh = wdata << {off, 3'b000};

        shifted = rdata >> {off, 3'b000};
        nbits   = 32'(nbytes) * 32'd8;
        if (nbits > XLEN) begin
            nbits = XLEN;
        end
        sidx = IDX_W'(nbits - 32'd1);
        sgn  = ~uns & shifted[sidx];
        // Bits below nbits come from memory, the rest are the extension bit.
        keep      = ~({XLEN{1'b1}} << nbits);
        rdata_ext = (shifted & keep) | ({XLEN{sgn}} & ~keep);
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: valid/ready request port in, variable-latency memory
// port out, one access in flight at a time.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wmask,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err
);

    localparam int unsigned OFF_W = $clog2(XLEN / 8);

    lsu_state_e        state_q, state_d;
    logic              wen_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;

    size_info_t        req_info;
    size_info_t        cur_info;
    logic              acc_err;
    logic [XLEN-1:0]   lane_wdata;
    logic [XLEN/8-1:0] lane_wmask;
    logic [XLEN-1:0]   lane_rdata;

    always_comb begin
        req_info = size_decode(req_funct3);
        cur_info = size_decode(f3_q);
        acc_err  = (req_funct3 == 3'b111)
                 | (req_wen & req_info.uns)
                 | ((XLEN == 32) & ((req_funct3 == F3_D) | (req_funct3 == F3_WU)))
                 | ((req_addr[3:0] & (req_info.nbytes - 4'd1)) != 4'd0);
    end

    lsu_lane #(
        .XLEN (XLEN)
    ) u_lane (
        .off       (addr_q[OFF_W-1:0]),
        .nbytes    (cur_info.nbytes),
        .uns       (cur_info.uns),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .wdata_sh  (lane_wdata),
        .wmask     (lane_wmask),
        .rdata_ext (lane_rdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = acc_err ? StResp : StReq;
                end
            end
            StReq: begin
                if (mem_ready) begin
                    state_d = wen_q ? StResp : StWait;
                end
            end
            StWait: begin
                if (mem_rvalid) begin
                    state_d = StResp;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            wen_q   <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req_valid) begin
                wen_q   <= req_wen;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= acc_err;
                rdata_q <= '0;
            end
            if (state_q == StWait && mem_rvalid) begin
                rdata_q <= lane_rdata;
            end
        end
    end

    always_comb begin
        req_ready  = (state_q == StIdle) & rst;
        mem_valid  = (state_q == StReq);
        mem_wen    = mem_valid & wen_q;
        mem_addr   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        mem_wdata  = lane_wdata;
        mem_wmask  = wen_q ? lane_wmask : '0;
        resp_valid = (state_q == StResp);
        resp_err   = resp_valid & err_q;
        resp_rdata = rdata_q;
    end

endmodule
